// File: rtl/pipelined_rv_exec_core.sv
// Three-stage RV32I/RV64I integer pipeline (decode/read, execute, writeback); FWD_EN selects forwarding, else interlock.
// Accept at edge t gives out_valid after edge t+2; a stalled result beat freezes all three stages and drops ins_ready.
module pipelined_rv_exec_core #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 32,
    parameter int ADD_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ins_valid,
    output logic                 ins_ready,
    input  logic [31:0]          instruction,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADD_WIDTH-1:0] out_rd,
    output logic [WIDTH-1:0]     out_data,
    output logic                 illegal
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    logic                 s1_vld_q, s1_vld_d;
    logic [31:0]          s1_ins_q, s1_ins_d;
    logic                 s2_vld_q, s2_vld_d;
    alu_op_e              s2_op_q, s2_op_d;
    logic [ADD_WIDTH-1:0] s2_rd_q, s2_rd_d;
    logic [WIDTH-1:0]     s2_op1_q, s2_op1_d;
    logic [WIDTH-1:0]     s2_op2_q, s2_op2_d;
    logic                 s3_vld_q, s3_vld_d;
    logic [ADD_WIDTH-1:0] s3_rd_q, s3_rd_d;
    logic [WIDTH-1:0]     s3_dat_q, s3_dat_d;
    logic                 illegal_q, illegal_d;
    logic [WIDTH-1:0]     rf_q [DEPTH];

    logic [6:0]           opc;
    logic [2:0]           f3;
    logic [6:0]           f7;
    logic [ADD_WIDTH-1:0] rs1_idx, rs2_idx, rd_idx;
    logic [WIDTH-1:0]     imm_i, imm_u;
    logic                 sh_lgc_ok, sh_ari_ok;
    logic                 dec_legal, dec_is_r, dec_is_lui;
    alu_op_e              dec_op;
    logic [WIDTH-1:0]     rf_rs1, rf_rs2, src1, src2;
    logic [WIDTH-1:0]     op1_sel, op2_sel;
    logic [WIDTH-1:0]     alu_res;
    logic [SHW-1:0]       shamt;
    logic                 hazard, stall_out, accept, retire;

    assign opc     = s1_ins_q[6:0];
    assign f3      = s1_ins_q[14:12];
    assign f7      = s1_ins_q[31:25];
    assign rd_idx  = s1_ins_q[7 +: ADD_WIDTH];
    assign rs1_idx = s1_ins_q[15 +: ADD_WIDTH];
    assign rs2_idx = s1_ins_q[20 +: ADD_WIDTH];
    assign imm_i   = WIDTH'($signed(s1_ins_q[31:20]));
    assign imm_u   = WIDTH'($signed({s1_ins_q[31:12], 12'b0}));

    // RV64 shift immediates carry a sixth shamt bit in instruction[25]
    generate
        if (WIDTH == 64) begin : g_sh64
            assign sh_lgc_ok = (s1_ins_q[31:26] == 6'b000000);
            assign sh_ari_ok = (s1_ins_q[31:26] == 6'b010000);
        end else begin : g_sh32
            assign sh_lgc_ok = (s1_ins_q[31:25] == 7'b0000000);
            assign sh_ari_ok = (s1_ins_q[31:25] == 7'b0100000);
        end
    endgenerate

    always_comb begin
        dec_legal  = 1'b0;
        dec_op     = ALU_ADD;
        dec_is_r   = 1'b0;
        dec_is_lui = 1'b0;
        case (opc)
            OPC_R: begin
                dec_is_r  = 1'b1;
                dec_legal = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: dec_op = ALU_ADD;
                    10'b0100000_000: dec_op = ALU_SUB;
                    10'b0000000_001: dec_op = ALU_SLL;
                    10'b0000000_010: dec_op = ALU_SLT;
                    10'b0000000_011: dec_op = ALU_SLTU;
                    10'b0000000_100: dec_op = ALU_XOR;
                    10'b0000000_101: dec_op = ALU_SRL;
                    10'b0100000_101: dec_op = ALU_SRA;
                    10'b0000000_110: dec_op = ALU_OR;
                    10'b0000000_111: dec_op = ALU_AND;
                    default:         dec_legal = 1'b0;
                endcase
            end
            OPC_I: begin
                dec_legal = 1'b1;
                case (f3)
                    3'b000: dec_op = ALU_ADD;
                    3'b010: dec_op = ALU_SLT;
                    3'b011: dec_op = ALU_SLTU;
                    3'b100: dec_op = ALU_XOR;
                    3'b110: dec_op = ALU_OR;
                    3'b111: dec_op = ALU_AND;
                    3'b001: begin
                        dec_op    = ALU_SLL;
                        dec_legal = sh_lgc_ok;
                    end
                    default: begin
                        dec_op    = sh_ari_ok ? ALU_SRA : ALU_SRL;
                        dec_legal = sh_lgc_ok | sh_ari_ok;
                    end
                endcase
            end
            OPC_LUI: begin
                dec_is_lui = 1'b1;
                dec_legal  = 1'b1;
            end
            default: ;
        endcase
    end

    assign rf_rs1 = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
    assign rf_rs2 = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];

`ifdef FWD_EN
    // Youngest producer wins; x0 is never a forwarding target
    always_comb begin
        src1 = rf_rs1;
        src2 = rf_rs2;
        if (rs1_idx != '0 && s2_vld_q && s2_rd_q == rs1_idx)      src1 = alu_res;
        else if (rs1_idx != '0 && s3_vld_q && s3_rd_q == rs1_idx) src1 = s3_dat_q;
        if (rs2_idx != '0 && s2_vld_q && s2_rd_q == rs2_idx)      src2 = alu_res;
        else if (rs2_idx != '0 && s3_vld_q && s3_rd_q == rs2_idx) src2 = s3_dat_q;
    end
    assign hazard = 1'b0;
`else
    logic uses_rs1, uses_rs2, dep_rs1, dep_rs2;
    assign src1     = rf_rs1;
    assign src2     = rf_rs2;
    assign uses_rs1 = dec_legal & ~dec_is_lui & (rs1_idx != '0);
    assign uses_rs2 = dec_legal & dec_is_r & (rs2_idx != '0);
    assign dep_rs1  = (s2_vld_q & (s2_rd_q == rs1_idx)) | (s3_vld_q & (s3_rd_q == rs1_idx));
    assign dep_rs2  = (s2_vld_q & (s2_rd_q == rs2_idx)) | (s3_vld_q & (s3_rd_q == rs2_idx));
    assign hazard   = s1_vld_q & ((uses_rs1 & dep_rs1) | (uses_rs2 & dep_rs2));
`endif

    assign op1_sel = dec_is_lui ? '0 : src1;
    assign op2_sel = dec_is_r ? src2 : (dec_is_lui ? imm_u : imm_i);

    assign shamt = s2_op2_q[SHW-1:0];

    always_comb begin
        alu_res = '0;
        case (s2_op_q)
            ALU_ADD:  alu_res = s2_op1_q + s2_op2_q;
            ALU_SUB:  alu_res = s2_op1_q - s2_op2_q;
            ALU_SLL:  alu_res = s2_op1_q << shamt;
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(s2_op1_q) < $signed(s2_op2_q))};
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (s2_op1_q < s2_op2_q)};
            ALU_XOR:  alu_res = s2_op1_q ^ s2_op2_q;
            ALU_SRL:  alu_res = s2_op1_q >> shamt;
            ALU_SRA:  alu_res = $unsigned($signed(s2_op1_q) >>> shamt);
            ALU_OR:   alu_res = s2_op1_q | s2_op2_q;
            ALU_AND:  alu_res = s2_op1_q & s2_op2_q;
            default:  alu_res = '0;
        endcase
    end

    assign stall_out = s3_vld_q & ~out_ready;
    assign ins_ready = ~rst & ~stall_out & ~hazard;
    assign accept    = ins_valid & ins_ready;
    assign retire    = s3_vld_q & out_ready;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_ins_d  = s1_ins_q;
        s2_vld_d  = s2_vld_q;
        s2_op_d   = s2_op_q;
        s2_rd_d   = s2_rd_q;
        s2_op1_d  = s2_op1_q;
        s2_op2_d  = s2_op2_q;
        s3_vld_d  = s3_vld_q;
        s3_rd_d   = s3_rd_q;
        s3_dat_d  = s3_dat_q;
        illegal_d = 1'b0;
        if (!stall_out) begin
            s3_vld_d  = s2_vld_q;
            s3_rd_d   = s2_rd_q;
            s3_dat_d  = alu_res;
            // Illegal words and interlocked slots both leave a bubble in S2
            s2_vld_d  = s1_vld_q & dec_legal & ~hazard;
            s2_op_d   = dec_op;
            s2_rd_d   = rd_idx;
            s2_op1_d  = op1_sel;
            s2_op2_d  = op2_sel;
            illegal_d = s1_vld_q & ~dec_legal;
            if (!hazard) begin
                s1_vld_d = accept;
                if (accept) s1_ins_d = instruction;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_ins_q  <= '0;
            s2_vld_q  <= 1'b0;
            s2_op_q   <= ALU_ADD;
            s2_rd_q   <= '0;
            s2_op1_q  <= '0;
            s2_op2_q  <= '0;
            s3_vld_q  <= 1'b0;
            s3_rd_q   <= '0;
            s3_dat_q  <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_ins_q  <= s1_ins_d;
            s2_vld_q  <= s2_vld_d;
            s2_op_q   <= s2_op_d;
            s2_rd_q   <= s2_rd_d;
            s2_op1_q  <= s2_op1_d;
            s2_op2_q  <= s2_op2_d;
            s3_vld_q  <= s3_vld_d;
            s3_rd_q   <= s3_rd_d;
            s3_dat_q  <= s3_dat_d;
            illegal_q <= illegal_d;
            if (retire && s3_rd_q != '0) rf_q[s3_rd_q] <= s3_dat_q;
        end
    end

    assign out_valid = s3_vld_q;
    assign out_rd    = s3_rd_q;
    assign out_data  = s3_dat_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_pipelined_rv_exec_core.sv
// Scoreboard bench for pipelined_rv_exec_core: expected beats queued at issue, compared in order at retire.
`timescale 1ns/1ps
module tb_pipelined_rv_exec_core;
    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
`ifdef FWD_EN
    localparam int DEP_GAP = 1;
`else
    localparam int DEP_GAP = 3;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ins_valid;
    logic             ins_ready;
    logic [31:0]      instruction;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_rd;
    logic [WIDTH-1:0] out_data;
    logic             illegal;

    always #5 clk = ~clk;

    pipelined_rv_exec_core #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADD_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
        .out_rd(out_rd), .out_data(out_data), .illegal(illegal)
    );

    typedef struct packed {
        logic [AW-1:0]    rd;
        logic [WIDTH-1:0] dat;
    } beat_t;

    beat_t exp_q[$];
    int    beat_cyc_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    ill_cnt = 0;
    int    acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        beat_t e;
        if (illegal === 1'b1) ill_cnt++;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            beat_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got rd=%0d data=%h, required no beat", out_rd, out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_rd !== e.rd || out_data !== e.dat) begin
                    n_fail++;
                    $display("FAIL beat: got rd=%0d data=%h, required rd=%0d data=%h",
                             out_rd, out_data, e.rd, e.dat);
                end
            end
        end
    end

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    // Offers one word until accepted; the expected beat (if any) is queued at issue.
    task automatic send(input logic [31:0] ins, input bit has_beat,
                        input logic [AW-1:0] rd, input logic [WIDTH-1:0] dat);
        int    waited;
        bit    acc;
        beat_t b;
        waited = 0;
        if (has_beat) begin
            b.rd  = rd;
            b.dat = dat;
            exp_q.push_back(b);
        end
        ins_valid   = 1'b1;
        instruction = ins;
        forever begin
            @(negedge clk);
            acc = ins_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 40) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got ins_ready=0 for 40 cycles, required acceptance of %h", ins);
                break;
            end
        end
        acc_cyc   = cyc;
        ins_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 80) begin
            @(posedge clk);
            #1;
            w++;
        end
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        ins_valid   = 1'b1;
        instruction = enc_i(12'd5, 5'd0, 3'b000, 5'd1);
        out_ready   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_tests++;
            if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ins_ready: got %b, required 0", ins_ready); end
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
            n_tests++;
            if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %h, required 0", out_data); end
            n_tests++;
            if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b, required 0", illegal); end
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        ins_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ins_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, required 1", ins_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_chain();
        beat_cyc_q.delete();
        send(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1, 5'd1, 32'd5);
        send(enc_r(7'h00, 5'd1, 5'd1, 3'b000, 5'd2), 1, 5'd2, 32'd10);
        send(enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3), 1, 5'd3, 32'd5);
        drain();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL chain_drain: got %0d outstanding, required 0", exp_q.size()); end
        n_tests++;
        if (beat_cyc_q.size() != 3) begin
            n_fail++;
            $display("FAIL chain_beats: got %0d beats, required 3", beat_cyc_q.size());
        end else begin
            if (beat_cyc_q[1] - beat_cyc_q[0] != DEP_GAP) begin
                n_fail++;
                $display("FAIL chain_gap1: got %0d cycles, required %0d", beat_cyc_q[1] - beat_cyc_q[0], DEP_GAP);
            end
            n_tests++;
            if (beat_cyc_q[2] - beat_cyc_q[1] != DEP_GAP) begin
                n_fail++;
                $display("FAIL chain_gap2: got %0d cycles, required %0d", beat_cyc_q[2] - beat_cyc_q[1], DEP_GAP);
            end
        end
    endtask

    task automatic test_imm();
        int start;
        beat_cyc_q.delete();
        send(enc_i(12'd5, 5'd0, 3'b000, 5'd1), 1, 5'd1, 32'd5);
        start = acc_cyc;
        drain();
        n_tests++;
        if (beat_cyc_q.size() != 1) begin
            n_fail++;
            $display("FAIL imm_beats: got %0d beats, required 1", beat_cyc_q.size());
        end else if (beat_cyc_q[0] - start != 2) begin
            n_fail++;
            $display("FAIL imm_latency: got %0d edges, required 2", beat_cyc_q[0] - start);
        end
        send(enc_i(12'hFFF, 5'd0, 3'b000, 5'd2), 1, 5'd2, 32'hFFFF_FFFF);
        send(enc_i(12'h800, 5'd0, 3'b000, 5'd4), 1, 5'd4, 32'hFFFF_F800);
        drain();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL imm_drain: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        beat_cyc_q.delete();
        out_ready = 1'b0;
        send(enc_i(12'd1, 5'd0, 3'b000, 5'd5), 1, 5'd5, 32'd1);
        send(enc_i(12'd2, 5'd0, 3'b000, 5'd6), 1, 5'd6, 32'd2);
        send(enc_i(12'd3, 5'd0, 3'b000, 5'd7), 1, 5'd7, 32'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ins_ready: got %b, required 0", ins_ready); end
            n_tests++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %b, required 1", out_valid); end
            n_tests++;
            if (out_rd !== 5'd5 || out_data !== 32'd1) begin
                n_fail++;
                $display("FAIL bp_hold: got rd=%0d data=%h, required rd=5 data=1", out_rd, out_data);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (beat_cyc_q.size() != 3) begin
            n_fail++;
            $display("FAIL bp_beats: got %0d beats, required 3", beat_cyc_q.size());
        end else if (beat_cyc_q[2] - beat_cyc_q[0] != 2) begin
            n_fail++;
            $display("FAIL bp_spacing: got %0d cycles, required 2", beat_cyc_q[2] - beat_cyc_q[0]);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] lw;
        lw = 32'h0000_2083;
        ill_cnt = 0;
        beat_cyc_q.delete();
        send(lw, 0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (ill_cnt != 1) begin n_fail++; $display("FAIL illegal_load: got %0d pulse cycles, required 1", ill_cnt); end
        n_tests++;
        if (beat_cyc_q.size() != 0) begin n_fail++; $display("FAIL illegal_beat: got %0d beats, required 0", beat_cyc_q.size()); end
        send(enc_r(7'h01, 5'd1, 5'd1, 3'b000, 5'd1), 0, '0, '0);
        send(enc_i({7'b0100000, 5'd1}, 5'd1, 3'b001, 5'd2), 0, '0, '0);
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (ill_cnt != 3) begin n_fail++; $display("FAIL illegal_funct7: got %0d pulse cycles, required 3", ill_cnt); end
        send(enc_i(12'd7, 5'd0, 3'b000, 5'd0), 1, 5'd0, 32'd7);
        send(enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd1), 1, 5'd1, 32'd0);
        drain();
        send(enc_r(7'h00, 5'd0, 5'd0, 3'b110, 5'd10), 1, 5'd10, 32'd0);
        drain();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL x0_drain: got %0d outstanding, required 0", exp_q.size()); end
        n_tests++;
        if (beat_cyc_q.size() != 3 || beat_cyc_q[1] - beat_cyc_q[0] != 1) begin
            n_fail++;
            $display("FAIL x0_no_bubble: got %0d beats, required 3 with x0 reader right behind", beat_cyc_q.size());
        end
    endtask

    task automatic test_signed();
        send(enc_lui(20'h80000, 5'd1), 1, 5'd1, 32'h8000_0000);
        send(enc_i({7'b0100000, 5'd4}, 5'd1, 3'b101, 5'd2), 1, 5'd2, 32'hF800_0000);
        send(enc_r(7'h00, 5'd1, 5'd0, 3'b011, 5'd3), 1, 5'd3, 32'd1);
        send(enc_r(7'h00, 5'd0, 5'd1, 3'b010, 5'd4), 1, 5'd4, 32'd1);
        send(enc_i(12'd8, 5'd0, 3'b000, 5'd6), 1, 5'd6, 32'd8);
        send(enc_r(7'h00, 5'd6, 5'd2, 3'b101, 5'd5), 1, 5'd5, 32'h00F8_0000);
        send(enc_r(7'h00, 5'd6, 5'd6, 3'b001, 5'd7), 1, 5'd7, 32'h0000_0800);
        send(enc_r(7'h00, 5'd1, 5'd2, 3'b100, 5'd8), 1, 5'd8, 32'h7800_0000);
        send(enc_r(7'h00, 5'd1, 5'd6, 3'b110, 5'd9), 1, 5'd9, 32'h8000_0008);
        send(enc_r(7'h00, 5'd1, 5'd2, 3'b111, 5'd10), 1, 5'd10, 32'h8000_0000);
        send(enc_i(12'hFFF, 5'd6, 3'b100, 5'd11), 1, 5'd11, 32'hFFFF_FFF7);
        send(enc_i(12'd7, 5'd6, 3'b110, 5'd12), 1, 5'd12, 32'h0000_000F);
        send(enc_i(12'h0FF, 5'd9, 3'b111, 5'd13), 1, 5'd13, 32'h0000_0008);
        send(enc_i(12'hFFF, 5'd1, 3'b010, 5'd14), 1, 5'd14, 32'd1);
        send(enc_i(12'hFFF, 5'd6, 3'b011, 5'd15), 1, 5'd15, 32'd1);
        send(enc_i({7'b0, 5'd31}, 5'd1, 3'b101, 5'd16), 1, 5'd16, 32'd1);
        send(enc_i({7'b0, 5'd28}, 5'd6, 3'b001, 5'd17), 1, 5'd17, 32'h8000_0000);
        send(enc_r(7'h00, 5'd1, 5'd0, 3'b010, 5'd18), 1, 5'd18, 32'd0);
        send(enc_r(7'h20, 5'd6, 5'd0, 3'b000, 5'd19), 1, 5'd19, 32'hFFFF_FFF8);
        send(enc_r(7'h20, 5'd6, 5'd1, 3'b101, 5'd20), 1, 5'd20, 32'hFF80_0000);
        send(enc_lui(20'h7FFFF, 5'd23), 1, 5'd23, 32'h7FFF_F000);
        drain();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL signed_drain: got %0d outstanding, required 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(enc_i(12'd3, 5'd0, 3'b000, 5'd21), 0, '0, '0);
        send(enc_i(12'd4, 5'd0, 3'b000, 5'd24), 0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ins_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b, required 0", ins_ready); end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b, required 0", out_valid); end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        beat_cyc_q.delete();
        send(enc_r(7'h00, 5'd7, 5'd6, 3'b000, 5'd25), 1, 5'd25, 32'd0);
        drain();
        repeat (4) @(posedge clk);
        #1;
        n_tests++;
        if (beat_cyc_q.size() != 1) begin n_fail++; $display("FAIL midreset_beats: got %0d beats, required 1", beat_cyc_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, required completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        ins_valid   = 1'b0;
        instruction = '0;
        out_ready   = 1'b1;
        test_reset();
        test_chain();
        test_imm();
        test_backpressure();
        test_illegal();
        test_signed();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL final_queue: got %0d outstanding, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_rv_exec_core.md
# pipelined_rv_exec_core

Parametrised three-stage RV32I/RV64I integer execution pipeline (decode/read, execute, writeback) with a valid/ready instruction input and a valid/ready result output. It replaces the fixed-width, memory-coupled CPU datapath. Instructions are supplied externally rather than from internal program memory. Immediates are sign-extended, full ALU op coverage is provided, and output back-pressure stalls the whole pipeline. Read-after-write hazards are resolved either by forwarding or by interlock, selected at compile time.

## Interface
- WIDTH, 32: datapath/register width; legal values 32 or 64.
- DEPTH, 32: number of architectural registers; power of two, 2..32.
- ADD_WIDTH, 5: register index width; must equal log2(DEPTH). Only the low ADD_WIDTH bits of rs1/rs2/rd are used.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- ins_valid  in  1  instruction word present.
- ins_ready  out  1  core accepts instruction this cycle; transfer when ins_valid & ins_ready.
- instruction  in  32  RISC-V instruction word.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts beat; retire when out_valid & out_ready.
- out_rd  out  ADD_WIDTH  destination register of the result.
- out_data  out  WIDTH  result value.
- illegal  out  1  one-cycle pulse: unsupported instruction dropped.

## Operation
- Supported instructions:
  - R-type (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - I-type (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - LUI (0110111).
- Everything else is illegal, including bad funct7 on R-type and shifts.
- Immediates:
  - I-imm = instruction[31:20] sign-extended to WIDTH.
  - LUI = {instruction[31:12], 12'b0} sign-extended to WIDTH.
- Shift amount = low log2(WIDTH) bits of op2. SLT/SLTU produce 0/1 zero-extended.
- Stages:
  - S1 (IF/ID register) holds the accepted word; decode and register read/forward are combinational from S1.
  - S2 (ID/EX) holds control, rd and operands; the ALU is combinational from S2.
  - S3 (EX/WB) holds rd and result; it drives out_valid/out_rd/out_data.
- Each stage has a valid bit.
- Register file: x0 reads 0 and is never written. The write to rd occurs on the retire edge (out_valid & out_ready), only when rd != 0.
- An illegal instruction in S1 becomes a bubble when it advances; illegal pulses on the following cycle. It produces no out beat and no write.
- Back-pressure: stall_out = out_valid & ~out_ready. While asserted, S1/S2/S3 hold and ins_ready = 0.
- Hazard (interlock build only): the S1 instruction is valid and reads rs1/rs2 (nonzero) equal to rd of a valid S2 or S3 entry. On a hazard, S1 holds, a bubble enters S2, S3 advances normally, and ins_ready = 0.
- ins_ready = ~rst & ~stall_out & ~hazard.
- Results retire strictly in program order; no beat is lost or duplicated.

## Timing
- Reset state: all valid bits 0, all registers 0, out_valid 0, out_rd 0, out_data 0, illegal 0, ins_ready 0 while rst is high.
- ins_ready is 1 in the first cycle after rst falls.
- Latency: an instruction accepted at edge t presents out_valid after edge t+2 (if no stall). Its register write happens at its retire edge.
- Throughput: one instruction per cycle with forwarding and out_ready held high.
- Forward priority for rs1/rs2 in S1: S2 ALU result > S3 out_data > register file. Rd = 0 is never forwarded.
- Same-edge write and read of one register: the S3 forward supplies the new value.
- Reset asserted mid-operation: all in-flight instructions are discarded and the register file is cleared on that edge.

## Configuration
- FWD_EN defined: forwarding paths active, hazard is constant 0, no dependency bubbles.
- FWD_EN undefined: no forwarding; the interlock stalls a dependent instruction until its producer has retired. With no back-pressure this costs 2 bubble cycles when the producer is immediately ahead.

## Test plan
- Reset: hold rst 2 cycles with ins_valid=1 -> ins_ready=0, out_valid=0, out_data=0. Then ins_ready=1 the cycle after release.
- Immediate sign-extension: ADDI x1,x0,5 accepted at t -> after edge t+2, out_valid=1, out_rd=1, out_data=5. ADDI x2,x0,-1 -> out_data=0xFFFFFFFF.
- Dependency chain ADDI x1,x0,5; ADD x2,x1,x1; SUB x3,x2,x1 back-to-back:
  - FWD_EN: beats 5, 10, 5 on consecutive cycles.
  - Without FWD_EN: same values, with 2 idle cycles before each dependent beat.
- Back-pressure: 3 instructions in flight, out_ready=0 for 3 cycles -> ins_ready=0 and out_data/out_rd held stable. The beats then retire in order with none lost or duplicated.
- Illegal and x0 handling: a load word (opcode 0000011) -> illegal pulses 1 cycle with no out beat. Then ADDI x0,x0,7; ADD x1,x0,x0 -> the second beat has out_data=0.
- Signed ops: LUI x1,0x80000 -> 0x80000000. Then SRAI x2,x1,4 -> 0xF8000000, SLTU x3,x0,x1 -> 1, SLT x4,x1,x0 -> 1.
